ifu_fetch_ctrl: RTL

Instruction fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the PC and issues sequential word fetches on a valid/ready instruction-bus request channel, and it collects in-order responses into a small buffer. It presents one {instruction, address} pair per cycle to the IF/ID register, honours pipeline hold, and redirects on jump. Responses that belong to a flushed stream are discarded.

---
 rtl/ifu_fetch_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch front end: owns the PC, issues sequential word fetches,
// buffers in-order responses and feeds the IF/ID register one instruction
// per cycle. A jump redirects the PC and discards the old stream.
//
// Request channel: a request transfers when ibus_req_valid_o and
// ibus_req_ready_i are both high at a rising edge. Once valid is raised,
// the address stays stable until the transfer, unless a jump or reset
// intervenes. Responses come back in order, one per cycle at most, with
// no backpressure.
module ifu_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic [2:0]  hold_flag_i,
    output logic        ibus_req_valid_o,
    input  logic        ibus_req_ready_i,
    output logic [31:0] ibus_req_addr_o,
    input  logic        ibus_rsp_valid_i,
    input  logic [31:0] ibus_rsp_data_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    localparam logic [31:0] INST_NOP  = 32'h0000_0001;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [2:0]  HOLD_IF   = 3'b010;
    localparam int          CW        = $clog2(FIFO_DEPTH + 1);
    localparam int          PW        = $clog2(FIFO_DEPTH);

    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outst_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_cnt;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   buf_data [FIFO_DEPTH];
    logic [31:0]   buf_addr [FIFO_DEPTH];

    logic [CW:0]   credit_used;
    logic          hold_en;
    logic          fire;
    logic          rsp_ok;
    logic          drop_rsp;
    logic          push;
    logic          pop;
    logic          fifo_nonempty;
    logic [31:0]   jump_target;

    // Handshake and credit decode; a stray response with nothing outstanding is ignored.
    always_comb begin
        credit_used      = {1'b0, outst_cnt} + {1'b0, fifo_cnt};
        hold_en          = (hold_flag_i >= HOLD_IF);
        fifo_nonempty    = (fifo_cnt != '0);
        jump_target      = {jump_addr_i[31:2], 2'b00};
        ibus_req_valid_o = rst_n & ~jump_flag_i & (credit_used < (CW+1)'(FIFO_DEPTH));
        ibus_req_addr_o  = pc;
        fire             = ibus_req_valid_o & ibus_req_ready_i;
        rsp_ok           = ibus_rsp_valid_i & (outst_cnt != '0);
        drop_rsp         = rsp_ok & (drop_cnt != '0);
        push             = rsp_ok & ~jump_flag_i & (drop_cnt == '0);
        pop              = fifo_nonempty & ~hold_en & ~jump_flag_i;
    end

    // PC, response address, credit counters and FIFO pointers; jump overrides everything but reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            rsp_pc    <= RESET_PC;
            outst_cnt <= '0;
            drop_cnt  <= '0;
            fifo_cnt  <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else if (jump_flag_i) begin
            pc        <= jump_target;
            rsp_pc    <= jump_target;
            // Everything still in flight after this cycle belongs to the old stream.
            outst_cnt <= outst_cnt - CW'(rsp_ok);
            drop_cnt  <= outst_cnt - CW'(rsp_ok);
            fifo_cnt  <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            if (fire) begin
                pc <= pc + 32'd4;
            end
            if (push) begin
                rsp_pc <= rsp_pc + 32'd4;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (drop_rsp) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            outst_cnt <= outst_cnt + CW'(fire) - CW'(rsp_ok);
            fifo_cnt  <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    // Buffer storage; contents only matter while counted as valid, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= ibus_rsp_data_i;
            buf_addr[wr_ptr] <= rsp_pc;
        end
    end

    // FIFO head drives the IF/ID inputs directly; a NOP bubble otherwise.
    always_comb begin
        inst_o       = INST_NOP;
        inst_addr_o  = ZERO_WORD;
        inst_valid_o = 1'b0;
        if (rst_n && !jump_flag_i && fifo_nonempty) begin
            inst_o       = buf_data[rd_ptr];
            inst_addr_o  = buf_addr[rd_ptr];
            inst_valid_o = 1'b1;
        end
    end

    rsp_without_request: assert property (
        @(posedge clk) disable iff (!rst_n) ibus_rsp_valid_i |-> (outst_cnt != '0)
    );

endmodule
